// File: rtl/crossbar_output_buffer_seq.sv
// Per-output-lane FWFT buffers behind a crossbar; one independent FIFO per lane.
// Optional CROSSBAR_OBUF_OCCUPANCY_EN exposes each lane's occupancy on o_count.
module crossbar_output_buffer_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_i,
  input  logic                        wr_vld_i,
  input  logic [DATA_WIDTH-1:0]       wr_data_i,
  input  logic                        rd_rdy_i,
  input  logic                        clr_ovf_i,
  output logic [DATA_WIDTH-1:0]       rd_data_o,
  output logic [$clog2(FIFO_DEPTH):0] cnt_o,
  output logic                        ovf_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  nempty, full, push, pop, drop;

  always_comb begin
    nempty   = (cnt_q != '0);
    full     = (cnt_q == DEPTH_C);
    pop      = en_i && nempty && rd_rdy_i;
    // a full lane still accepts a word when the head leaves in the same cycle
    push     = en_i && wr_vld_i && (!full || pop);
    drop     = en_i && wr_vld_i && full && !pop;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    ovf_d    = drop || (ovf_q && !clr_ovf_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // storage is deliberately not reset; the empty-lane mask hides stale entries
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = nempty ? mem_q[rd_ptr_q] : '0;
  assign cnt_o     = cnt_q;
  assign ovf_o     = ovf_q;
endmodule

module crossbar_output_buffer_seq #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_OUTPUT_DATA = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                  CLK,
  input  logic                                  rst,
  input  logic [NUM_OUTPUT_DATA-1:0]            i_valid,
  input  logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0] i_data_bus,
  input  logic                                  i_en,
  input  logic [NUM_OUTPUT_DATA-1:0]            i_ready,
  input  logic [NUM_OUTPUT_DATA-1:0]            i_clr_ovf,
  output logic [NUM_OUTPUT_DATA-1:0]            o_valid,
  output logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0] o_data_bus,
  output logic [NUM_OUTPUT_DATA-1:0]            o_full,
  output logic [NUM_OUTPUT_DATA-1:0]            o_overflow
`ifdef CROSSBAR_OBUF_OCCUPANCY_EN
  ,
  output logic [NUM_OUTPUT_DATA*($clog2(FIFO_DEPTH)+1)-1:0] o_count
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [NUM_OUTPUT_DATA-1:0][CW-1:0]         cnt;
  logic [NUM_OUTPUT_DATA-1:0][DATA_WIDTH-1:0] rd_data;

  for (genvar k = 0; k < NUM_OUTPUT_DATA; k++) begin : g_lane
    crossbar_output_buffer_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_lane (
      .clk       (CLK),
      .rst       (rst),
      .en_i      (i_en),
      .wr_vld_i  (i_valid[k]),
      .wr_data_i (i_data_bus[k*DATA_WIDTH +: DATA_WIDTH]),
      .rd_rdy_i  (i_ready[k]),
      .clr_ovf_i (i_clr_ovf[k]),
      .rd_data_o (rd_data[k]),
      .cnt_o     (cnt[k]),
      .ovf_o     (o_overflow[k])
    );
    assign o_valid[k] = (cnt[k] != '0);
    assign o_full[k]  = (cnt[k] == DEPTH_C);
  end

  assign o_data_bus = rd_data;
`ifdef CROSSBAR_OBUF_OCCUPANCY_EN
  assign o_count = cnt;
`endif
endmodule

// File: tb/tb_crossbar_output_buffer_seq.sv
// Directed bench for crossbar_output_buffer_seq at 32b x 16 lanes x depth 4.
module tb_crossbar_output_buffer_seq;
  localparam int DW = 32;
  localparam int NL = 16;
  localparam int FD = 4;

  logic               CLK = 1'b0;
  logic               rst;
  logic [NL-1:0]      i_valid, i_ready, i_clr_ovf;
  logic [NL*DW-1:0]   i_data_bus;
  logic               i_en;
  logic [NL-1:0]      o_valid, o_full, o_overflow;
  logic [NL*DW-1:0]   o_data_bus;
`ifdef CROSSBAR_OBUF_OCCUPANCY_EN
  logic [NL*($clog2(FD)+1)-1:0] o_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  crossbar_output_buffer_seq #(.DATA_WIDTH(DW), .NUM_OUTPUT_DATA(NL), .FIFO_DEPTH(FD)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .i_en       (i_en),
    .i_ready    (i_ready),
    .i_clr_ovf  (i_clr_ovf),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus),
    .o_full     (o_full),
    .o_overflow (o_overflow)
`ifdef CROSSBAR_OBUF_OCCUPANCY_EN
    ,
    .o_count    (o_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] head(input int k);
    return o_data_bus[k*DW +: DW];
  endfunction

  // advance one edge; inputs and checks land 1 time unit after the edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input int k, input logic [DW-1:0] v);
    i_valid[k] = 1'b1;
    i_data_bus[k*DW +: DW] = v;
  endtask

  logic [DW-1:0] exp7 [4];

  initial begin
    rst = 1'b1; i_en = 1'b0; i_valid = '0; i_ready = '0; i_clr_ovf = '0; i_data_bus = '0;
    step(); step();
    chk("rst_valid", 64'(o_valid), 64'h0);
    chk("rst_full", 64'(o_full), 64'h0);
    chk("rst_ovf", 64'(o_overflow), 64'h0);
    chk("rst_data", 64'(|o_data_bus), 64'h0);
    rst = 1'b0;
    i_en = 1'b1;

    // single word on lane 0, one-cycle latency
    put(0, 32'hA5A5_0001);
    chk("no_bypass", 64'(o_valid), 64'h0);
    step();
    i_valid = '0;
    chk("l0_valid", 64'(o_valid), 64'h0001);
    chk("l0_data", 64'(head(0)), 64'hA5A5_0001);
    i_ready[0] = 1'b1;
    step();
    i_ready = '0;
    chk("l0_drained", 64'(o_valid[0]), 64'h0);
    chk("l0_data_zero", 64'(head(0)), 64'h0);

    // lane 3: fill, then overflow on the 5th write
    for (int i = 1; i <= 5; i++) begin
      put(3, DW'(i));
      step();
      if (i == 3) chk("l3_not_full", 64'(o_full[3]), 64'h0);
      if (i == 4) begin
        chk("l3_full", 64'(o_full[3]), 64'h1);
        chk("l3_no_ovf", 64'(o_overflow[3]), 64'h0);
      end
      if (i == 5) chk("l3_ovf", 64'(o_overflow[3]), 64'h1);
    end
    i_valid = '0;
    i_ready[3] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("l3_drain%0d", i), 64'(head(3)), 64'(i));
      step();
    end
    chk("l3_empty", 64'(o_valid[3]), 64'h0);
    i_ready = '0;

    // lane 7: write + pop on a full lane succeeds without overflow
    for (int i = 0; i < 4; i++) begin
      put(7, DW'(32'h11 + i));
      step();
    end
    put(7, 32'h9);
    i_ready[7] = 1'b1;
    step();
    i_valid = '0;
    chk("l7_full_kept", 64'(o_full[7]), 64'h1);
    chk("l7_no_ovf", 64'(o_overflow[7]), 64'h0);
    exp7[0] = 32'h12; exp7[1] = 32'h13; exp7[2] = 32'h14; exp7[3] = 32'h9;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("l7_drain%0d", i), 64'(head(7)), 64'(exp7[i]));
      step();
    end
    chk("l7_empty", 64'(o_valid[7]), 64'h0);
    i_ready = '0;

    // freeze with i_en=0
    put(1, 32'h21); step();
    put(1, 32'h22); step();
    i_en = 1'b0;
    i_valid = '1; i_ready = '1;
    i_data_bus = {NL{32'hDEAD_BEEF}};
    step(); step(); step();
    chk("frz_valid", 64'(o_valid), 64'h0002);
    chk("frz_full", 64'(o_full), 64'h0);
    chk("frz_ovf", 64'(o_overflow), 64'h0008);
    chk("frz_head", 64'(head(1)), 64'h21);
    i_valid = '0; i_ready = '0;
    i_clr_ovf[3] = 1'b1;
    step();
    i_clr_ovf = '0;
    chk("clr_while_dis", 64'(o_overflow), 64'h0);
    i_en = 1'b1;
    i_ready[1] = 1'b1;
    step();
    chk("l1_second", 64'(head(1)), 64'h22);
    step();
    i_ready = '0;
    chk("l1_empty", 64'(o_valid[1]), 64'h0);

    // lane 2: drop beats clear, then a lone clear wins
    for (int i = 0; i < 5; i++) begin
      put(2, DW'(32'h31 + i));
      step();
    end
    chk("l2_ovf", 64'(o_overflow[2]), 64'h1);
    put(2, 32'h77);
    i_clr_ovf[2] = 1'b1;
    step();
    i_valid = '0;
    chk("l2_set_wins", 64'(o_overflow[2]), 64'h1);
    step();
    i_clr_ovf = '0;
    chk("l2_cleared", 64'(o_overflow[2]), 64'h0);
    chk("l2_head", 64'(head(2)), 64'h31);
    i_ready[2] = 1'b1;
    step(); step(); step();
    chk("l2_last", 64'(head(2)), 64'h34);
    step();
    i_ready = '0;
    chk("l2_empty", 64'(o_valid[2]), 64'h0);

    // lane 15: streaming through pointer wrap, then async reset mid-stream
    i_ready[15] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      put(15, DW'(32'h100 + i));
      step();
      chk($sformatf("l15_stream%0d", i), 64'(head(15)), 64'(32'h100 + i));
    end
    i_ready = '0;
    put(15, 32'h200);
    step();
    i_valid = '0;
    chk("l15_pre_rst", 64'(o_valid), 64'h8001 & 64'h8000 | 64'h8000);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(o_valid), 64'h0);
    chk("async_rst_data", 64'(|o_data_bus), 64'h0);
    step();
    rst = 1'b0;
    put(15, 32'hBEEF);
    step();
    i_valid = '0;
    chk("post_rst_valid", 64'(o_valid), 64'h8000);
    chk("post_rst_data", 64'(head(15)), 64'hBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/crossbar_output_buffer_seq.md
CROSSBAR_OUTPUT_BUFFER_SEQ -- requirements
Module: crossbar_output_buffer_seq

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, meaning the bits per data word.
REQ-002 The module SHALL have parameter NUM_OUTPUT_DATA, default 16, meaning the number of independent lanes (one per crossbar output).
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 4, meaning the entries per lane; it is a power of 2 and at least 2.
REQ-004 The module SHALL have port CLK, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The module SHALL have port i_valid, input, NUM_OUTPUT_DATA bits: per-lane word-present flags from the crossbar.
REQ-007 The module SHALL have port i_data_bus, input, NUM_OUTPUT_DATA*DATA_WIDTH bits: lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The module SHALL have port i_en, input, 1 bit: global enable; when low, all lane state is frozen.
REQ-009 The module SHALL have port i_ready, input, NUM_OUTPUT_DATA bits: per-lane consumer ready.
REQ-010 The module SHALL have port i_clr_ovf, input, NUM_OUTPUT_DATA bits: per-lane sticky-overflow clear pulse.
REQ-011 The module SHALL have port o_valid, output, NUM_OUTPUT_DATA bits: lane head word valid.
REQ-012 The module SHALL have port o_data_bus, output, NUM_OUTPUT_DATA*DATA_WIDTH bits: lane head word, using the same packing as i_data_bus.
REQ-013 The module SHALL have port o_full, output, NUM_OUTPUT_DATA bits: lane occupancy equals FIFO_DEPTH.
REQ-014 The module SHALL have port o_overflow, output, NUM_OUTPUT_DATA bits: sticky flag meaning a lane dropped a word.

Function
REQ-015 Each lane SHALL be an independent first-word-fall-through FIFO: o_valid[k] = (count[k] != 0), and o_data_bus lane k = the entry at the read pointer.
REQ-016 A write to lane k SHALL occur at a rising edge when i_en=1, i_valid[k]=1, and (count[k] < FIFO_DEPTH or a pop occurs in the same cycle).
REQ-017 A pop from lane k SHALL occur at a rising edge when i_en=1, o_valid[k]=1 and i_ready[k]=1.
REQ-018 Read and write pointers SHALL be log2(FIFO_DEPTH) bits and wrap from FIFO_DEPTH-1 to 0; count SHALL be log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
REQ-019 Latency SHALL be one cycle: a word written at edge t appears on o_valid/o_data_bus after edge t, with no same-cycle combinational bypass when empty.
REQ-020 Simultaneous write and pop on a non-empty lane SHALL leave count unchanged and advance both pointers.
REQ-021 Simultaneous write and pop on a full lane SHALL succeed, and o_overflow SHALL NOT be set.
REQ-022 When i_valid[k]=1 and i_en=1 on a full lane with no pop, the word SHALL be dropped, and o_overflow[k] SHALL be set at that edge.
REQ-023 When i_en=0, pointers, counts and flags SHALL hold; i_valid SHALL be ignored (not counted as overflow); o_valid and o_data_bus SHALL still reflect the current state.
REQ-024 i_clr_ovf[k] SHALL clear o_overflow[k] regardless of i_en; if a drop and a clear occur in the same cycle, the set wins.
REQ-025 Lanes SHALL NOT interact; the behaviour of lane k depends only on lane-k inputs plus i_en.

Reset
REQ-026 On rst=1, asynchronously: all counts and pointers SHALL be 0, o_valid=0, o_full=0, o_overflow=0, and o_data_bus=0.
REQ-027 Storage array contents SHALL NOT be reset; o_data_bus SHALL be forced to 0 whenever count=0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered words; the first write after release SHALL land in entry 0.

Configuration
REQ-029 Macro CROSSBAR_OBUF_OCCUPANCY_EN defined: the module SHALL add output port o_count, NUM_OUTPUT_DATA*(log2(FIFO_DEPTH)+1) bits, carrying each lane's count packed lane-major, with reset value 0.
REQ-030 Macro CROSSBAR_OBUF_OCCUPANCY_EN undefined: the o_count port SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then i_en=1, lane 0 i_valid for 1 cycle with data 0xA5A5_0001, i_ready=0 -> the next cycle shows o_valid[0]=1 and lane-0 data 0xA5A5_0001; other lanes show o_valid=0.
REQ-032 Lane 3 receives 5 consecutive writes (0x1..0x5) with i_ready=0 and FIFO_DEPTH=4 -> o_full[3]=1 after the 4th write, o_overflow[3]=1 after the 5th; draining yields 0x1,0x2,0x3,0x4 and nothing more.
REQ-033 Lane 7 full, then write 0x9 with i_ready[7]=1 in the same cycle -> no overflow, count stays 4, and the drain order ends with 0x9.
REQ-034 i_en=0 for 3 cycles with i_valid=all ones and i_ready=all ones -> counts unchanged and o_overflow unchanged.
REQ-035 With o_overflow[2]=1, pulse i_clr_ovf[2] in the same cycle as a new drop -> o_overflow[2] stays 1; a clear pulse alone the next cycle -> 0.
REQ-036 Write 10 words through lane 15 with continuous i_ready=1 -> the output order matches the input order across pointer wrap, and rst asserted mid-stream -> o_valid=0 immediately (asynchronously).
